// File: rtl/fir_stream_driver.sv
`default_nettype none
// ============================================================================
// Module   : fir_stream_driver
// Purpose  : Loads FIR coefficients into a MAC accelerator and streams
//            buffered sensor samples into it, capturing its results.
// Revision : 1.0 - initial release
// ============================================================================
module fir_stream_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         loadReq,
    input  logic                         coeffValid,
    input  logic signed [DATA_WIDTH-1:0] coeffData,
    output logic                         coeffReady,
    input  logic                         sampleValid,
    input  logic        [DATA_WIDTH-1:0] sampleData,
    output logic                         sampleReady,
    output logic                         coeffWriteEn,
    output logic        [2:0]            coeffAddress,
    output logic signed [DATA_WIDTH-1:0] coeffIn,
    output logic                         clrC,
    output logic                         accelerateEn,
    output logic        [DATA_WIDTH-1:0] rawSensorVal,
    input  logic signed [DATA_WIDTH-1:0] macResult,
    input  logic                         resultIsValid,
    input  logic                         busy,
    output logic                         resultValid,
    output logic signed [DATA_WIDTH-1:0] resultData,
    input  logic                         resultReady,
    output logic                         loaded,
    output logic                         overflow,
    output logic        [15:0]           sampleCount
);

    localparam int c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int c_AW    = $clog2(FIFO_DEPTH);

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REGS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_AW:0]      c_PTR_ONE  = (c_AW + 1)'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOAD   = 2'd1;
    localparam logic [1:0] c_CLEAR  = 2'd2;
    localparam logic [1:0] c_STREAM = 2'd3;

    logic [1:0]                   r_state;
    logic [c_IDX_W-1:0]           r_idx;
    logic                         r_coeffWriteEn;
    logic [2:0]                   r_coeffAddress;
    logic signed [DATA_WIDTH-1:0] r_coeffIn;

    logic [DATA_WIDTH-1:0]        r_mem [FIFO_DEPTH];
    logic [c_AW:0]                r_wrPtr;
    logic [c_AW:0]                r_rdPtr;
    logic                         r_accelerateEn;
    logic [DATA_WIDTH-1:0]        r_rawSensorVal;
    logic [15:0]                  r_sampleCount;
    logic                         r_resultValid;
    logic signed [DATA_WIDTH-1:0] r_resultData;
    logic                         r_overflow;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_capture;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[c_AW] != r_rdPtr[c_AW]) &&
                     (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);

    assign w_pop     = (r_state == c_STREAM) && !w_empty && !busy &&
                       (!r_resultValid || resultReady);
    assign w_push    = sampleValid && sampleReady;
    assign w_capture = resultIsValid && (!r_resultValid || resultReady);

    // A full buffer still takes a sample in a cycle that frees a slot.
    assign sampleReady  = !rst && (!w_full || w_pop);
    assign coeffReady   = (r_state == c_LOAD);
    assign clrC         = (r_state == c_CLEAR);
    assign loaded       = (r_state == c_STREAM);
    assign coeffWriteEn = r_coeffWriteEn;
    assign coeffAddress = r_coeffAddress;
    assign coeffIn      = r_coeffIn;
    assign accelerateEn = r_accelerateEn;
    assign rawSensorVal = r_rawSensorVal;
    assign resultValid  = r_resultValid;
    assign resultData   = r_resultData;
    assign overflow     = r_overflow;
    assign sampleCount  = r_sampleCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_idx          <= '0;
            r_coeffWriteEn <= 1'b0;
            r_coeffAddress <= '0;
            r_coeffIn      <= '0;
        end else begin
            r_coeffWriteEn <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (loadReq) begin
                        r_state <= c_LOAD;
                        r_idx   <= '0;
                    end
                end
                c_LOAD: begin
                    if (coeffValid) begin
                        r_coeffWriteEn <= 1'b1;
                        r_coeffAddress <= 3'(r_idx);
                        r_coeffIn      <= coeffData;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_CLEAR;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end
                end
                c_CLEAR: begin
                    r_state <= c_STREAM;
                end
                c_STREAM: begin
                    if (loadReq) begin
                        r_state <= c_LOAD;
                        r_idx   <= '0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[c_AW-1:0]] <= sampleData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr        <= '0;
            r_rdPtr        <= '0;
            r_accelerateEn <= 1'b0;
            r_rawSensorVal <= '0;
            r_sampleCount  <= '0;
            r_resultValid  <= 1'b0;
            r_resultData   <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_accelerateEn <= w_pop;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr        <= r_rdPtr + c_PTR_ONE;
                r_rawSensorVal <= r_mem[r_rdPtr[c_AW-1:0]];
            end
            if (r_state == c_CLEAR) begin
                r_sampleCount <= '0;
            end else if (w_pop) begin
                r_sampleCount <= r_sampleCount + 16'd1;
            end
            // A result arriving while the held one is still unconsumed is dropped.
            if (w_capture) begin
                r_resultData  <= macResult;
                r_resultValid <= 1'b1;
            end else if (resultIsValid) begin
                r_overflow <= 1'b1;
            end else if (resultReady) begin
                r_resultValid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
